// File: rtl/iir_pkg.sv
// iir_pkg: shared types, sizes, Chebyshev-I coefficients (Q11.52) and output saturation
// Constants: ORDER taps per direction, WORD sample width, FRAC fraction bits, ACC_W accumulator width.
// Coefficients: 9th-order Chebyshev-I lowpass, 0.5 dB ripple, cutoff fs/4, unity DC gain.
package iir_pkg;
    localparam int ORDER = 9;
    localparam int WORD  = 64;
    localparam int FRAC  = 52;
    localparam int ACC_W = 2 * WORD + 5;
    localparam int TAPS  = 2 * ORDER + 1;
    localparam int TAP_W = $clog2(TAPS);
    localparam int IDX_W = $clog2(ORDER + 1);
    typedef logic signed [WORD-1:0]  word_t;
    typedef logic signed [ACC_W-1:0] acc_t;
    typedef logic [TAP_W-1:0]        tap_t;
    typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;
    localparam word_t SAT_MAX = {1'b0, {(WORD-1){1'b1}}};
    localparam word_t SAT_MIN = {1'b1, {(WORD-1){1'b0}}};
    // b_k = b0 * C(9,k): numerator is b0 * (1 + z^-1)^9
    localparam word_t B_COEF [ORDER+1] = '{
        64'sd3787351646233,   64'sd34086164816097,  64'sd136344659264388,
        64'sd318137538283572, 64'sd477206307425358, 64'sd477206307425358,
        64'sd318137538283572, 64'sd136344659264388, 64'sd34086164816097,
        64'sd3787351646233
    };
    // a_0 is the implicit 1.0 and is never read by the datapath
    localparam word_t A_COEF [ORDER+1] = '{
        64'sd4503599627370496,   -64'sd11703432294053670, 64'sd23543256102822256,
        -64'sd32572014088979470, 64'sd35627539802964139,  -64'sd30394239942369312,
        64'sd20336274333369117,  -64'sd10310820210078810, 64'sd3663115346912477,
        -64'sd754154779200954
    };
    // Floor-shift back to Q11.52 and clamp to the signed WORD range
    function automatic word_t saturate(input acc_t acc);
        acc_t s;
        s = acc >>> FRAC;
        return s > acc_t'(SAT_MAX) ? SAT_MAX : s < acc_t'(SAT_MIN) ? SAT_MIN : word_t'(s);
    endfunction
endpackage

// File: rtl/iir_cheby1_lowpass_folded_if.sv
// iir_cheby1_lowpass_folded_if: valid/ready sample stream in and out of the filter
// in_data/in_valid/in_ready: input sample handshake; out_data/out_valid/out_ready: result handshake.
// master = sample source and result sink, slave = filter.
interface iir_cheby1_lowpass_folded_if;
    import iir_pkg::*;
    word_t in_data;
    logic  in_valid;
    logic  in_ready;
    word_t out_data;
    logic  out_valid;
    logic  out_ready;
    modport master (output in_data, in_valid, out_ready, input in_ready, out_data, out_valid);
    modport slave (input in_data, in_valid, out_ready, output in_ready, out_data, out_valid);
endinterface

// File: rtl/iir_coef_rom.sv
// iir_coef_rom: tap index -> coefficient and subtract flag
// tap 0..ORDER selects b_k (added); tap ORDER+1..2*ORDER selects a_(tap-ORDER) (subtracted).
// Ports: tap (in), coef (out, Q11.52), sub (out, 1 = subtract product).
module iir_coef_rom
    import iir_pkg::*;
(
    input  tap_t  tap,
    output word_t coef,
    output logic  sub
);
    always_comb begin
        sub  = tap > tap_t'(ORDER);
        coef = !sub ? B_COEF[tap[IDX_W-1:0]]
             : tap < tap_t'(TAPS) ? A_COEF[IDX_W'(tap - tap_t'(ORDER))] : '0;
    end
endmodule

// File: rtl/iir_cheby1_lowpass_folded.sv
// iir_cheby1_lowpass_folded: 9th-order Chebyshev-I lowpass, one time-shared multiplier
// Ports: clock, reset (sync, active-high), bus (slave: in_* sample stream in, out_* result stream out).
// One sample takes 1 IDLE + 19 MAC + >=1 OUT cycles; filter history moves only on the output handshake.
module iir_cheby1_lowpass_folded
    import iir_pkg::*;
(
    input logic                        clock,
    input logic                        reset,
    iir_cheby1_lowpass_folded_if.slave bus
);
    state_t state, state_n;
    tap_t tap;
    word_t x_line [ORDER+1];
    word_t y_line [ORDER];
    word_t coef, operand, y_reg;
    logic sub, in_hs, out_hs, last;
    logic signed [2*WORD-1:0] prod;
    acc_t acc, acc_n;

    iir_coef_rom u_rom (.tap(tap), .coef(coef), .sub(sub));

    assign bus.in_ready  = state == IDLE && !reset;
    assign bus.out_valid = state == OUT && !reset;
    assign bus.out_data  = y_reg;
    assign in_hs   = bus.in_valid && bus.in_ready;
    assign out_hs  = bus.out_valid && bus.out_ready;
    assign last    = tap == tap_t'(TAPS - 1);
    // x_line[0] holds the sample being filtered; x_line[1..] and y_line[0..] are the history
    assign operand = tap <= tap_t'(ORDER) ? x_line[tap[IDX_W-1:0]] : y_line[IDX_W'(tap - tap_t'(ORDER + 1))];
    // Sign-extended operands: a single WORDxWORD signed product
    assign prod    = (2*WORD)'(coef) * (2*WORD)'(operand);
    assign acc_n   = sub ? acc - acc_t'(prod) : acc + acc_t'(prod);

    always_ff @(posedge clock) state <= reset ? IDLE : state_n;

    always_comb begin
        state_n = state;
        if (state == IDLE && in_hs) state_n = MAC;
        if (state == MAC && last) state_n = OUT;
        if (state == OUT && out_hs) state_n = IDLE;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            tap    <= '0;
            acc    <= '0;
            y_reg  <= '0;
            x_line <= '{default: '0};
            y_line <= '{default: '0};
        end else begin
            if (in_hs) begin
                x_line[0] <= bus.in_data;
                acc       <= '0;
                tap       <= '0;
            end
            if (state == MAC) begin
                acc <= acc_n;
                tap <= tap + tap_t'(1);
                if (last) y_reg <= saturate(acc_n);
            end
            if (out_hs) begin
                for (int k = ORDER; k > 0; k--) x_line[k] <= x_line[k-1];
                y_line[0] <= y_reg;
                for (int k = ORDER - 1; k > 0; k--) y_line[k] <= y_line[k-1];
            end
        end
    end
endmodule

// File: doc/iir_cheby1_lowpass_folded.md
IIR_CHEBY1_LOWPASS_FOLDED -- requirements
Module: iir_cheby1_lowpass_folded

Interface
REQ-001 Parameter ORDER, 9, filter order (number of delay taps per direction).
REQ-002 Parameter WORD, 64, sample and coefficient width, signed two's complement.
REQ-003 Parameter FRAC, 52, fractional bits of samples and coefficients (Q11.52).
REQ-004 Port clock, input, 1, rising-edge clock.
REQ-005 Port reset, input, 1, synchronous, active-high.
REQ-006 Port in_data, input, WORD, input sample x[n].
REQ-007 Port in_valid, input, 1, in_data valid.
REQ-008 Port in_ready, output, 1, block can accept a sample.
REQ-009 Port out_data, output, WORD, filtered sample y[n], Q11.52.
REQ-010 Port out_valid, output, 1, out_data valid.
REQ-011 Port out_ready, input, 1, downstream accepts out_data.

Function
REQ-012 Shall compute y[n] = sum(k=0..ORDER) b_k*x[n-k] - sum(k=1..ORDER) a_k*y[n-k], with the 9th-order Chebyshev-I lowpass b0..b9, a1..a9 coefficient set (Q11.52).
REQ-013 Shall use exactly one signed WORDxWORD multiplier, time-multiplexed; one product per cycle.
REQ-014 FSM states IDLE, MAC, OUT; reset state IDLE.
REQ-015 IDLE: in_ready=1, out_valid=0; on in_valid&&in_ready, capture in_data, clear accumulator, go MAC next cycle.
REQ-016 MAC: 2*ORDER+1 cycles (19), tap index 0..18: indices 0..9 accumulate +b_k*x[n-k], indices 10..18 accumulate -a_k*y[n-k]; in_ready=0.
REQ-017 After the last MAC cycle go OUT; out_valid asserts first OUT cycle, i.e. 20 cycles after the input handshake cycle.
REQ-018 Accumulator signed, WORD*2+5 bits (133); no intermediate overflow possible.
REQ-019 Result = accumulator arithmetic-shifted right FRAC bits (truncation toward minus infinity), then saturated to WORD bits: clamp to 0x7FFF_FFFF_FFFF_FFFF / 0x8000_0000_0000_0000.
REQ-020 Saturated result drives out_data and is the value stored as y[n] in the feedback delay line.
REQ-021 OUT: out_data and out_valid held stable until out_ready=1; in_ready=0 throughout.
REQ-022 On OUT handshake (out_valid&&out_ready): shift x and y delay lines by one (x[n], y[n] enter tap 1), go IDLE next cycle.
REQ-023 Delay lines shall change only on the OUT handshake; backpressure of any length shall not alter filter state.
REQ-024 Minimum sample period 21 cycles (1 IDLE + 19 MAC + 1 OUT with out_ready=1).
REQ-025 in_valid during MAC/OUT ignored (in_ready=0); no sample is dropped if source obeys valid/ready.

Reset
REQ-026 reset=1 at any clock edge: state IDLE, all x and y delay taps 0, accumulator 0, out_valid=0, out_data=0, in_ready=0 while reset asserted, in_ready=1 first cycle after release.
REQ-027 Reset during MAC or OUT aborts the computation; no out_valid for the aborted sample.

Structure
REQ-028 Package iir_pkg holds ORDER, WORD, FRAC, accumulator width, saturation limits, and b/a coefficient constant arrays.
REQ-029 Sub-module iir_coef_rom: combinational lookup, tap index 0..18 -> signed coefficient and sign (add/subtract) flag.
REQ-030 Delay lines, FSM, multiplier, accumulator reside in iir_cheby1_lowpass_folded; target 150-300 RTL lines.

Verification
REQ-031 Impulse: in_data=0x0010_0000_0000_0000 (1.0) then zeros, out_ready=1 -> y[0]=b0 bit-exact, y[1]=trunc(b1-a1*b0), first 64 outputs match bit-exact double-to-Q11.52 reference model.
REQ-032 Zero stimulus: 100 samples of 0 after reset -> 100 outputs of exactly 0.
REQ-033 Backpressure: out_ready=0 for 10 cycles in OUT -> out_valid=1 and out_data unchanged all 10 cycles, in_ready=0, subsequent outputs identical to no-backpressure run.
REQ-034 Timing: handshake at cycle t, out_ready=1 -> out_valid at t+20, in_ready at t+21; back-to-back source gives one output per 21 cycles.
REQ-035 Reset mid-MAC: reset asserted 5 cycles after input handshake -> no out_valid; next impulse response identical to REQ-031.
REQ-036 Saturation: constant in_data=0x7FFF_FFFF_FFFF_FFFF for 200 samples -> out_data never wraps sign; clamps to 0x7FFF_FFFF_FFFF_FFFF wherever the reference model exceeds the range.
